// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request, single-entry buffer toward decode.
// Optional IFU_MISALIGN_CHECK_EN traps misaligned redirects into a sticky error state.
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_misalign
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        drop_q, drop_d;
   logic        misalign_q, misalign_d;

   logic [31:0] redir_tgt;
   logic        redir_bad;
   logic        take_redir;

`ifdef IFU_MISALIGN_CHECK_EN
   assign redir_tgt = redirect_pc;
   assign redir_bad = redirect_pc[1:0] != 2'b00;
`else
   logic unused_redir_lo;
   assign unused_redir_lo = ^redirect_pc[1:0];
   assign redir_tgt       = {redirect_pc[31:2], 2'b00};
   assign redir_bad       = 1'b0;
`endif

   // The error state swallows redirects entirely.
   assign take_redir = redirect_valid && (state_q != S_ERR);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      drop_d     = drop_q;
      misalign_d = misalign_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (take_redir) pc_d = redir_tgt;
         end
         S_REQ: begin
            if (take_redir) begin
               pc_d = redir_tgt;
               if (imem_req_ready) begin
                  drop_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end else if (imem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (take_redir) begin
               pc_d = redir_tgt;
               if (imem_resp_valid) begin
                  // The stale response completes here, so nothing is left to drop.
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (imem_resp_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  inst_d    = imem_resp_data;
                  inst_pc_d = pc_q;
                  state_d   = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (take_redir) begin
               pc_d    = redir_tgt;
               state_d = S_REQ;
            end else if (inst_ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = S_REQ;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (take_redir && redir_bad) begin
         misalign_d = 1'b1;
         state_d    = S_ERR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         inst_q     <= 32'd0;
         inst_pc_q  <= 32'd0;
         drop_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         drop_q     <= drop_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (state_q == S_HOLD);
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
   assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: random-latency memory model plus a program-order scoreboard of delivered
// instructions (expected PC advances by 4 per delivery, jumps to each redirect target).
module tb_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_misalign;

   always #5 clk = ~clk;

   ifu dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_ready      (inst_ready),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .fetch_misalign  (fetch_misalign)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // memory model
   logic        mem_busy = 1'b0;
   logic [31:0] mem_addr;
   int          mem_wait;
   int          lat_min = 1;
   int          lat_max = 1;

   // scoreboard state
   logic [31:0] exp_pc;
   int          n_req;
   logic [31:0] last_req_addr;
   logic        req_now;
   int          n_del;
   logic        del_now;
   logic [31:0] del_pc;
   int          del_gap;
   int          last_del_cyc;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_inst, prev_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   // Advance to the next negedge, drive the memory response, check buffered-instruction hold.
   task automatic tick();
      @(negedge clk);
      cyc++;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_busy) begin
         if (mem_wait <= 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr);
            mem_busy        = 1'b0;
         end else begin
            mem_wait--;
         end
      end
      if (prev_hold) begin
         n_cmp++;
         if (inst_valid !== 1'b1 || inst !== prev_inst || inst_pc !== prev_pc) begin
            n_err++;
            $display("FAIL hold_stable: valid %b inst %h pc %h, required 1 %h %h",
                     inst_valid, inst, inst_pc, prev_inst, prev_pc);
         end
      end
   endtask

   // Record what the upcoming posedge will do with the inputs just driven.
   task automatic commit();
      req_now = 1'b0;
      del_now = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
         mem_busy      = 1'b1;
         mem_addr      = imem_req_addr;
         mem_wait      = $urandom_range(lat_max, lat_min) - 1;
         n_req++;
         last_req_addr = imem_req_addr;
         req_now       = 1'b1;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
         n_cmp++;
         if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
            n_err++;
            $display("FAIL deliver: pc %h inst %h, required pc %h inst %h",
                     inst_pc, inst, exp_pc, mem_word(exp_pc));
         end
         del_now      = 1'b1;
         del_pc       = inst_pc;
         del_gap      = cyc - last_del_cyc;
         last_del_cyc = cyc;
         exp_pc       = exp_pc + 32'd4;
         n_del++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      prev_hold = inst_valid && !inst_ready && !redirect_valid;
      prev_inst = inst;
      prev_pc   = inst_pc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
      inst_ready      = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'd0;
      mem_busy        = 1'b0;
      prev_hold       = 1'b0;
      exp_pc          = RESET_PC;
      n_req           = 0;
      n_del           = 0;
      last_del_cyc    = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drive(input logic rq, input logic ir, input logic rv, input logic [31:0] rp);
      imem_req_ready = rq;
      inst_ready     = ir;
      redirect_valid = rv;
      redirect_pc    = rp;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_misalign !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctl: req %b valid %b mis %b, required 0 0 0",
                  imem_req_valid, inst_valid, fetch_misalign);
      end
      n_cmp++;
      if (imem_req_addr !== RESET_PC || inst !== 32'd0 || inst_pc !== 32'd0) begin
         n_err++;
         $display("FAIL reset_data: addr %h inst %h pc %h, required %h 0 0",
                  imem_req_addr, inst, inst_pc, RESET_PC);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         n_err++;
         $display("FAIL first_req: valid %b addr %h, required 1 %h",
                  imem_req_valid, imem_req_addr, RESET_PC);
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      commit();
   endtask

   task automatic test_zero_wait();
      logic [31:0] exp_addr;
      do_reset();
      lat_min  = 1;
      lat_max  = 1;
      exp_addr = RESET_PC;
      for (int i = 0; i < 14; i++) begin
         tick();
         drive(1'b1, 1'b1, 1'b0, 32'd0);
         commit();
         if (req_now && n_req <= 3) begin
            n_cmp++;
            if (last_req_addr !== exp_addr) begin
               n_err++;
               $display("FAIL seq_addr: got %h, required %h", last_req_addr, exp_addr);
            end
            exp_addr = exp_addr + 32'd4;
         end
         if (del_now && n_del >= 2) begin
            n_cmp++;
            if (del_gap != 3) begin
               n_err++;
               $display("FAIL throughput: gap %0d cycles, required 3", del_gap);
            end
         end
      end
      n_cmp++;
      if (n_del < 3) begin
         n_err++;
         $display("FAIL zero_wait_count: %0d deliveries, required >= 3", n_del);
      end
   endtask

   task automatic test_stall();
      int hold_cnt = 0;
      logic done = 1'b0;
      do_reset();
      lat_min = 4;
      lat_max = 4;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         drive(1'b1, hold_cnt >= 5, 1'b0, 32'd0);
         if (inst_valid) begin
            n_cmp++;
            if (imem_req_valid !== 1'b0) begin
               n_err++;
               $display("FAIL stall_req: req_valid %b while holding, required 0", imem_req_valid);
            end
            hold_cnt++;
         end
         commit();
         if (del_now) begin
            done = 1'b1;
            n_cmp++;
            if (n_req != 1 || hold_cnt != 6) begin
               n_err++;
               $display("FAIL stall_accept: reqs %0d hold %0d, required 1 6", n_req, hold_cnt);
            end
         end
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL stall_timeout: no delivery, required one within 40 cycles");
      end
   endtask

   task automatic test_redirect_wait();
      logic fired = 1'b0;
      logic got = 1'b0;
      int   req0 = 0;
      int   del0 = 0;
      do_reset();
      lat_min = 3;
      lat_max = 3;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (!fired && mem_busy && !imem_req_valid && !inst_valid) begin
            drive(1'b1, 1'b1, 1'b1, 32'h8000_0100);
            fired = 1'b1;
            req0  = n_req;
            del0  = n_del;
         end else begin
            drive(1'b1, 1'b1, 1'b0, 32'd0);
         end
         commit();
         if (fired && req_now && n_req == req0 + 1) begin
            got = 1'b1;
            n_cmp++;
            if (last_req_addr !== 32'h8000_0100 || n_del != del0) begin
               n_err++;
               $display("FAIL redirect_wait: addr %h dels %0d, required 80000100 %0d",
                        last_req_addr, n_del, del0);
            end
         end
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL redirect_wait_timeout: no request after redirect");
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         drive(1'b1, 1'b1, 1'b0, 32'd0);
         commit();
      end
      n_cmp++;
      if (n_del <= del0) begin
         n_err++;
         $display("FAIL redirect_wait_progress: %0d deliveries, required > %0d", n_del, del0);
      end
   endtask

   task automatic test_hold_redirect();
      logic fired = 1'b0;
      logic got = 1'b0;
      do_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 30 && !got; i++) begin
         tick();
         if (!fired && inst_valid) begin
            drive(1'b1, 1'b1, 1'b1, 32'h8000_0200);
            fired = 1'b1;
         end else begin
            drive(1'b1, 1'b1, 1'b0, 32'd0);
         end
         commit();
         if (fired && req_now) begin
            got = 1'b1;
            n_cmp++;
            if (last_req_addr !== 32'h8000_0200) begin
               n_err++;
               $display("FAIL hold_redirect: addr %h, required 80000200", last_req_addr);
            end
         end
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL hold_redirect_timeout: no request after redirect");
      end
   endtask

   task automatic test_wrap();
      logic wrap_seen = 1'b0;
      logic got = 1'b0;
      do_reset();
      lat_min = 1;
      lat_max = 2;
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      commit();
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         drive(1'b1, 1'b1, 1'b0, 32'd0);
         commit();
         if (wrap_seen && req_now) begin
            got = 1'b1;
            n_cmp++;
            if (last_req_addr !== 32'd0) begin
               n_err++;
               $display("FAIL wrap: addr %h, required 00000000", last_req_addr);
            end
         end
         if (del_now && del_pc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL wrap_timeout: no request after FFFFFFFC delivery");
      end
   endtask

   task automatic test_misalign();
      logic fired = 1'b0;
      do_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 20 && !fired; i++) begin
         tick();
         if (inst_valid) begin
            drive(1'b1, 1'b0, 1'b1, 32'h8000_0102);
            fired = 1'b1;
         end else begin
            drive(1'b1, 1'b0, 1'b0, 32'd0);
         end
         commit();
      end
`ifdef IFU_MISALIGN_CHECK_EN
      for (int i = 0; i < 15; i++) begin
         tick();
         drive(1'b1, 1'b1, (i == 3), 32'h8000_0400);
         n_cmp++;
         if (fetch_misalign !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_err: mis %b req %b valid %b, required 1 0 0",
                     fetch_misalign, imem_req_valid, inst_valid);
         end
         commit();
      end
`else
      for (int i = 0; i < 20 && fired; i++) begin
         tick();
         drive(1'b1, 1'b1, 1'b0, 32'd0);
         commit();
         if (req_now) begin
            fired = 1'b0;
            n_cmp++;
            if (last_req_addr !== 32'h8000_0100 || fetch_misalign !== 1'b0) begin
               n_err++;
               $display("FAIL misalign_off: addr %h mis %b, required 80000100 0",
                        last_req_addr, fetch_misalign);
            end
         end
      end
      if (fired) begin
         n_cmp++;
         n_err++;
         $display("FAIL misalign_off_timeout: no request after redirect");
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] tgt;
      int total = 0;
      do_reset();
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            total += n_del;
            do_reset();
         end
         tick();
         tgt = {8'h80, 22'($urandom), 2'b00};
         if ($urandom_range(7, 0) == 0) tgt = 32'hFFFF_FFF0 | {28'd0, 2'($urandom), 2'b00};
         drive($urandom_range(3, 0) != 0, $urandom_range(4, 0) < 3,
               $urandom_range(14, 0) == 0, tgt);
         commit();
      end
      total += n_del;
      n_cmp++;
      if (total < 100) begin
         n_err++;
         $display("FAIL random_progress: %0d deliveries, required >= 100", total);
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect_wait();
      test_hold_redirect();
      test_wrap();
      test_misalign();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-issue NPC core. Holds the program counter, fetches one 32-bit instruction per round trip over a request/response instruction-memory handshake, and hands the instruction word with its PC to decode (opcode decode and immediate generation) over a valid/ready handshake. Accepts PC redirects from execute (branch/jump targets computed from the generated immediate) and discards any fetch that becomes stale.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request present
- imem_req_addr  out  32  fetch address, equals current PC
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  response data valid (always accepted, no backpressure)
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  buffered instruction available to decode
- inst  out  32  instruction word to decode
- inst_pc  out  32  PC of `inst`
- inst_ready  in  1  decode consumes instruction this cycle
- redirect_valid  in  1  execute requests PC change
- redirect_pc  in  32  new PC
- fetch_misalign  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR. Outputs are decoded from registered state only; no combinational input-to-output paths.
- Reset: state S_IDLE; pc = RESET_PC; inst = 0; inst_pc = 0; drop = 0; fetch_misalign = 0. All outputs 0 except imem_req_addr = RESET_PC.
- S_IDLE: unconditionally to S_REQ on the next edge.
- S_REQ: imem_req_valid = 1, imem_req_addr = pc. On imem_req_ready, go to S_WAIT.
- S_WAIT: on imem_resp_valid, if drop = 1 then discard data, clear drop, go to S_REQ. Otherwise latch inst = imem_resp_data and inst_pc = pc, then go to S_HOLD.
- S_HOLD: inst_valid = 1. On inst_ready, set pc = pc + 4 (modulo 2^32, wraps 32'hFFFF_FFFC to 0) and go to S_REQ.
- Redirect has priority over every other event in the same cycle:
  - S_REQ, request not accepted: pc = redirect_pc, stay in S_REQ.
  - S_REQ, request accepted in the same cycle: pc = redirect_pc, drop = 1, go to S_WAIT.
  - S_WAIT, no response: pc = redirect_pc, drop = 1.
  - S_WAIT, response in the same cycle: discard the response, pc = redirect_pc, drop stays 0, go to S_REQ.
  - S_HOLD, with or without inst_ready: discard the buffered instruction, pc = redirect_pc, go to S_REQ. No pc + 4 is applied.
  - S_IDLE: pc = redirect_pc. S_ERR: ignored.
- A second redirect while drop = 1 only updates pc. drop is a single bit because at most one request is outstanding.
- Reset asserted mid-transaction returns to S_IDLE immediately. The memory must also be reset; any response arriving in S_IDLE or S_REQ is ignored.

## Timing
- First imem_req_valid is asserted 1 cycle after rst deasserts.
- A response is sampled only in S_WAIT, so it arrives no earlier than 1 cycle after request acceptance.
- inst_valid rises on the cycle after the response cycle.
- Best case is 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory and decode ready.
- inst and inst_pc are stable while inst_valid = 1 and no redirect is applied.
- A redirect takes effect on the next edge. The new PC appears on imem_req_addr no later than 1 cycle after the stale response, or immediately in S_REQ.

## Configuration
- IFU_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_misalign = 1 (sticky) and moves to S_ERR.
  - S_ERR issues no requests and holds inst_valid = 0 until reset.
  - pc is still updated to the misaligned target for debug.
- Not defined:
  - fetch_misalign is tied 0.
  - redirect_pc[1:0] is treated as 2'b00.
  - No S_ERR transitions occur.

## Test plan
- Reset release, zero-wait memory, inst_ready = 1: requests go to 80000000, 80000004, 80000008. inst_valid pulses carry the matching inst_pc and data, one instruction every 3 cycles.
- Response 4 cycles late, inst_ready low for 5 cycles: no second request is issued, and inst/inst_pc stay stable until the accept.
- Redirect to 80000100 in S_WAIT, response 2 cycles later: that response is dropped, the next request address is 80000100, and no inst_valid is produced for the dropped fetch.
- Redirect and inst_ready in the same S_HOLD cycle: the instruction is discarded, and the next address is the redirect target, not pc + 4.
- pc = FFFFFFFC accepted by decode: the next request address is 00000000.
- With IFU_MISALIGN_CHECK_EN, redirect to 80000102: fetch_misalign = 1 and no further imem_req_valid until reset. Without the macro, the next request goes to 80000100.
